// File: rtl/aes_stream_packer.sv
// Width adapter between 32-bit HWPE streams and the 128-bit AES core, with per-job block counting.
// Optional build macro AES_PACKER_BYTESWAP_EN byte-reverses every 32-bit word on both paths.
module aes_stream_packer #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    num_blocks_i,
  input  logic                pt_valid_i,
  output logic                pt_ready_o,
  input  logic [WORD_W-1:0]   pt_data_i,
  output logic                blk_valid_o,
  input  logic                blk_ready_i,
  output logic [4*WORD_W-1:0] blk_data_o,
  input  logic                ct_valid_i,
  output logic                ct_ready_o,
  input  logic [4*WORD_W-1:0] ct_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [WORD_W-1:0]   out_data_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int BLK_W = 4 * WORD_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   in_left_q, in_left_d;
  logic [CNT_W-1:0]   out_left_q, out_left_d;
  logic [1:0]         pack_cnt_q, pack_cnt_d;
  logic [1:0]         unpack_cnt_q, unpack_cnt_d;
  logic [BLK_W-1:0]   pack_q, pack_d;
  logic [BLK_W-1:0]   unpack_q, unpack_d;
  logic               blk_valid_q, blk_valid_d;
  logic               unpack_full_q, unpack_full_d;

  logic               pt_hs, blk_hs, ct_hs, out_hs;
  logic               last_out_word;
  logic [WORD_W-1:0]  pt_word;
  logic [WORD_W-1:0]  unpack_word;

  // Memory byte order of the AES state differs from the core's word order in the little-endian build.
  function automatic logic [WORD_W-1:0] word_order(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
`ifdef AES_PACKER_BYTESWAP_EN
    for (int b = 0; b < WORD_W / 8; b++) begin
      r[8*b +: 8] = w[WORD_W-8-8*b +: 8];
    end
`else
    r = w;
`endif
    return r;
  endfunction

  // Readies are built from registered state only, so no ready-to-ready path exists.
  assign pt_ready_o  = (state_q == RUN) && !blk_valid_q && (in_left_q != '0);
  assign ct_ready_o  = (state_q == RUN) && !unpack_full_q && (out_left_q != '0);
  assign blk_valid_o = blk_valid_q;
  assign blk_data_o  = pack_q;
  assign out_valid_o = unpack_full_q;
  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);

  assign pt_hs  = pt_valid_i && pt_ready_o;
  assign blk_hs = blk_valid_q && blk_ready_i;
  assign ct_hs  = ct_valid_i && ct_ready_o;
  assign out_hs = unpack_full_q && out_ready_i;
  assign last_out_word = out_hs && (unpack_cnt_q == 2'd3);

  assign pt_word = word_order(pt_data_i);

  always_comb begin
    unpack_word = '0;
    case (unpack_cnt_q)
      2'd0:    unpack_word = unpack_q[4*WORD_W-1 -: WORD_W];
      2'd1:    unpack_word = unpack_q[3*WORD_W-1 -: WORD_W];
      2'd2:    unpack_word = unpack_q[2*WORD_W-1 -: WORD_W];
      default: unpack_word = unpack_q[WORD_W-1 -: WORD_W];
    endcase
  end

  assign out_data_o = word_order(unpack_word);

  always_comb begin
    state_d       = state_q;
    in_left_d     = in_left_q;
    out_left_d    = out_left_q;
    pack_cnt_d    = pack_cnt_q;
    unpack_cnt_d  = unpack_cnt_q;
    pack_d        = pack_q;
    unpack_d      = unpack_q;
    blk_valid_d   = blk_valid_q;
    unpack_full_d = unpack_full_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          in_left_d     = num_blocks_i;
          out_left_d    = num_blocks_i;
          pack_cnt_d    = 2'd0;
          unpack_cnt_d  = 2'd0;
          blk_valid_d   = 1'b0;
          unpack_full_d = 1'b0;
          state_d       = (num_blocks_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_out_word && (out_left_q == CNT_ONE)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pack: first word ends up in the top lane after four shifts.
    if (pt_hs) begin
      pack_d     = {pack_q[BLK_W-WORD_W-1:0], pt_word};
      pack_cnt_d = pack_cnt_q + 2'd1;
      if (pack_cnt_q == 2'd3) begin
        blk_valid_d = 1'b1;
        in_left_d   = in_left_q - CNT_ONE;
      end
    end
    if (blk_hs) begin
      blk_valid_d = 1'b0;
    end

    // Unpack: one captured block drains as four words, top lane first.
    if (ct_hs) begin
      unpack_d      = ct_data_i;
      unpack_full_d = 1'b1;
    end
    if (out_hs) begin
      unpack_cnt_d = unpack_cnt_q + 2'd1;
      if (last_out_word) begin
        unpack_full_d = 1'b0;
        out_left_d    = out_left_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= IDLE;
      in_left_q     <= '0;
      out_left_q    <= '0;
      pack_cnt_q    <= '0;
      unpack_cnt_q  <= '0;
      pack_q        <= '0;
      unpack_q      <= '0;
      blk_valid_q   <= 1'b0;
      unpack_full_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_left_q     <= in_left_d;
      out_left_q    <= out_left_d;
      pack_cnt_q    <= pack_cnt_d;
      unpack_cnt_q  <= unpack_cnt_d;
      pack_q        <= pack_d;
      unpack_q      <= unpack_d;
      blk_valid_q   <= blk_valid_d;
      unpack_full_q <= unpack_full_d;
    end
  end

endmodule

// File: tb/tb_aes_stream_packer.sv
// Self-checking bench for aes_stream_packer: directed scenarios plus randomized jobs against a queue model.
// Honours AES_PACKER_BYTESWAP_EN so the same bench covers both builds.
`timescale 1ns/1ps
module tb_aes_stream_packer;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             clear;
  logic             start_i;
  logic [CNT_W-1:0] num_blocks_i;
  logic             pt_valid_i, pt_ready_o;
  logic [31:0]      pt_data_i;
  logic             blk_valid_o, blk_ready_i;
  logic [127:0]     blk_data_o;
  logic             ct_valid_i, ct_ready_o;
  logic [127:0]     ct_data_i;
  logic             out_valid_o, out_ready_i;
  logic [31:0]      out_data_o;
  logic             busy_o, done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_stream_packer #(.WORD_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .clear(clear), .start_i(start_i), .num_blocks_i(num_blocks_i),
    .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o), .pt_data_i(pt_data_i),
    .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i), .blk_data_o(blk_data_o),
    .ct_valid_i(ct_valid_i), .ct_ready_o(ct_ready_o), .ct_data_i(ct_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  function automatic logic [31:0] sw(input logic [31:0] w);
    logic [31:0] r;
    r = w;
`ifdef AES_PACKER_BYTESWAP_EN
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
`endif
    return r;
  endfunction

  function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {sw(a), sw(b), sw(c), sw(d)};
  endfunction

  function automatic logic [31:0] ct_word(input logic [127:0] c, input int k);
    logic [127:0] t;
    t = c << (32 * k);
    return sw(t[127:96]);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; num_blocks_i = '0;
    pt_valid_i = 1'b0; pt_data_i = '0; blk_ready_i = 1'b0;
    ct_valid_i = 1'b0; ct_data_i = '0; out_ready_i = 1'b0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    clear = 1'b1;
    tick(); tick();
    checks++;
    if ({pt_ready_o, blk_valid_o, ct_ready_o, out_valid_o, busy_o, done_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {pt_ready_o, blk_valid_o, ct_ready_o, out_valid_o, busy_o, done_o});
    end
    checks++;
    if (blk_data_o !== '0 || out_data_o !== '0) begin
      errors++;
      $display("FAIL reset_data: got blk=%h out=%h expected zeros", blk_data_o, out_data_o);
    end
    clear = 1'b0;
    tick();
    checks++;
    if ({pt_ready_o, ct_ready_o, busy_o, done_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b expected 0000", {pt_ready_o, ct_ready_o, busy_o, done_o});
    end
  endtask

  task automatic test_single_block();
    logic [31:0]  w [4];
    logic [127:0] c;
    w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    c = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
    do_clear();
    start_i = 1'b1; num_blocks_i = CNT_W'(1);
    tick();
    start_i = 1'b0;
    checks++;
    if ({busy_o, pt_ready_o} !== 2'b11) begin
      errors++;
      $display("FAIL start_latency: got busy,pt_ready=%b expected 11", {busy_o, pt_ready_o});
    end
    for (int i = 0; i < 4; i++) begin
      pt_valid_i = 1'b1; pt_data_i = w[i];
      checks++;
      if (pt_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL single_pt_ready word %0d: got %b expected 1", i, pt_ready_o);
      end
      tick();
    end
    pt_valid_i = 1'b0;
    checks++;
    if (blk_valid_o !== 1'b1 || blk_data_o !== pack4(w[0], w[1], w[2], w[3])) begin
      errors++;
      $display("FAIL single_blk: got valid=%b data=%h expected 1 %h", blk_valid_o, blk_data_o,
               pack4(w[0], w[1], w[2], w[3]));
    end
    blk_ready_i = 1'b1;
    tick();
    blk_ready_i = 1'b0;
    checks++;
    if ({blk_valid_o, pt_ready_o, ct_ready_o} !== 3'b001) begin
      errors++;
      $display("FAIL single_after_blk: got blk_valid,pt_ready,ct_ready=%b expected 001",
               {blk_valid_o, pt_ready_o, ct_ready_o});
    end
    ct_valid_i = 1'b1; ct_data_i = c; out_ready_i = 1'b1;
    tick();
    ct_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== ct_word(c, k) || done_o !== 1'b0) begin
        errors++;
        $display("FAIL single_out word %0d: got valid=%b data=%h done=%b expected 1 %h 0",
                 k, out_valid_o, out_data_o, done_o, ct_word(c, k));
      end
      tick();
    end
    checks++;
    if ({done_o, busy_o, out_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL single_done: got done,busy,out_valid=%b expected 100", {done_o, busy_o, out_valid_o});
    end
    out_ready_i = 1'b0;
    tick();
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL single_done_width: got done=%b expected 0", done_o);
    end
  endtask

  task automatic test_zero_blocks();
    do_clear();
    start_i = 1'b1; num_blocks_i = '0;
    pt_valid_i = 1'b1; pt_data_i = $urandom;
    ct_valid_i = 1'b1; ct_data_i = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start_i = 1'b0;
    checks++;
    if ({done_o, busy_o, pt_ready_o, ct_ready_o} !== 4'b1000) begin
      errors++;
      $display("FAIL zero_done: got done,busy,pt_ready,ct_ready=%b expected 1000",
               {done_o, busy_o, pt_ready_o, ct_ready_o});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({done_o, busy_o, pt_ready_o, ct_ready_o} !== 4'b0000) begin
        errors++;
        $display("FAIL zero_after cycle %0d: got %b expected 0000", i,
                 {done_o, busy_o, pt_ready_o, ct_ready_o});
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [31:0]  w [4];
    logic [127:0] exp_blk, c;
    int got, cyc;
    do_clear();
    start_i = 1'b1; num_blocks_i = CNT_W'(1);
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      pt_valid_i = 1'b1; pt_data_i = w[i];
      tick();
    end
    exp_blk = pack4(w[0], w[1], w[2], w[3]);
    pt_data_i = $urandom;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (blk_valid_o !== 1'b1 || blk_data_o !== exp_blk || pt_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_blk_hold cycle %0d: got valid=%b data=%h pt_ready=%b expected 1 %h 0",
                 i, blk_valid_o, blk_data_o, pt_ready_o, exp_blk);
      end
      tick();
    end
    blk_ready_i = 1'b1;
    tick();
    blk_ready_i = 1'b0; pt_valid_i = 1'b0;
    checks++;
    if (blk_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_blk_release: got valid=%b expected 0", blk_valid_o);
    end
    c = {$urandom, $urandom, $urandom, $urandom};
    ct_valid_i = 1'b1; ct_data_i = c;
    tick();
    ct_valid_i = 1'b0; ct_data_i = ~c;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 40) begin
      out_ready_i = ((cyc % 2) == 1);
      if (out_valid_o) begin
        checks++;
        if (out_data_o !== ct_word(c, got)) begin
          errors++;
          $display("FAIL bp_out word %0d: got %h expected %h", got, out_data_o, ct_word(c, got));
        end
        if (out_ready_i) got++;
      end
      tick();
      cyc++;
    end
    out_ready_i = 1'b0;
    checks++;
    if (got != 4 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: got words=%0d done=%b expected 4 1", got, done_o);
    end
  endtask

  task automatic test_count_enforcement();
    logic [31:0]  words [12];
    logic [127:0] ctq [$];
    logic [31:0]  expo [$];
    logic [127:0] exp_blk;
    int acc, nblk, outs, dones, over, cyc, ct_t0, last_out, done_cyc;
    do_clear();
    for (int i = 0; i < 12; i++) words[i] = $urandom;
    acc = 0; nblk = 0; outs = 0; dones = 0; over = 0; ct_t0 = -1; last_out = -2; done_cyc = -1;
    start_i = 1'b1; num_blocks_i = CNT_W'(2);
    tick();
    start_i = 1'b0;
    blk_ready_i = 1'b1; out_ready_i = 1'b1;
    for (cyc = 0; cyc < 80; cyc++) begin
      if (done_o) begin dones++; done_cyc = cyc; end
      if (acc >= 8 && pt_ready_o) over++;
      pt_valid_i = (acc < 12);
      pt_data_i  = words[(acc < 12) ? acc : 0];
      if (blk_valid_o) begin
        exp_blk = (nblk < 2) ? pack4(words[4*nblk], words[4*nblk+1], words[4*nblk+2], words[4*nblk+3]) : '0;
        checks++;
        if (nblk >= 2 || blk_data_o !== exp_blk) begin
          errors++;
          $display("FAIL cnt_blk %0d: got %h expected %h", nblk, blk_data_o, exp_blk);
        end
        ctq.push_back({$urandom, $urandom, $urandom, $urandom});
        nblk++;
      end
      ct_valid_i = (ctq.size() != 0);
      ct_data_i  = (ctq.size() != 0) ? ctq[0] : '0;
      if (ct_t0 >= 0 && (cyc == ct_t0 + 4 || cyc == ct_t0 + 5)) begin
        checks++;
        if (ct_ready_o !== (cyc == ct_t0 + 5)) begin
          errors++;
          $display("FAIL ct_ready_recover at +%0d: got %b expected %b", cyc - ct_t0, ct_ready_o,
                   (cyc == ct_t0 + 5));
        end
      end
      if (ct_valid_i && ct_ready_o) begin
        if (ct_t0 < 0) ct_t0 = cyc;
        for (int k = 0; k < 4; k++) expo.push_back(ct_word(ctq[0], k));
        ctq.pop_front();
      end
      if (out_valid_o) begin
        checks++;
        if (expo.size() == 0) begin
          errors++;
          $display("FAIL cnt_out_extra: got %h expected no word", out_data_o);
        end else begin
          if (out_data_o !== expo[0]) begin
            errors++;
            $display("FAIL cnt_out %0d: got %h expected %h", outs, out_data_o, expo[0]);
          end
          expo.pop_front();
        end
        outs++;
        if (outs == 8) last_out = cyc;
      end
      if (pt_valid_i && pt_ready_o) acc++;
      tick();
    end
    idle_inputs();
    checks++;
    if (acc != 8 || over != 0 || outs != 8 || dones != 1 || done_cyc != last_out + 1) begin
      errors++;
      $display("FAIL cnt_totals: got acc=%0d over=%0d outs=%0d dones=%0d done_at=%0d expected 8 0 8 1 %0d",
               acc, over, outs, dones, done_cyc, last_out + 1);
    end
  endtask

  task automatic test_clear_mid_job();
    logic [31:0] w [4];
    do_clear();
    start_i = 1'b1; num_blocks_i = CNT_W'(1);
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pt_valid_i = 1'b1; pt_data_i = $urandom | 32'h1;
      tick();
    end
    pt_valid_i = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if ({pt_ready_o, blk_valid_o, ct_ready_o, out_valid_o, busy_o, done_o} !== 6'b0 ||
        blk_data_o !== '0 || out_data_o !== '0) begin
      errors++;
      $display("FAIL clear_mid: got ctrl=%b blk=%h out=%h expected zeros",
               {pt_ready_o, blk_valid_o, ct_ready_o, out_valid_o, busy_o, done_o}, blk_data_o, out_data_o);
    end
    start_i = 1'b1; num_blocks_i = CNT_W'(1);
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      pt_valid_i = 1'b1; pt_data_i = w[i];
      tick();
    end
    pt_valid_i = 1'b0;
    checks++;
    if (blk_valid_o !== 1'b1 || blk_data_o !== pack4(w[0], w[1], w[2], w[3])) begin
      errors++;
      $display("FAIL clear_restart_blk: got valid=%b data=%h expected 1 %h", blk_valid_o, blk_data_o,
               pack4(w[0], w[1], w[2], w[3]));
    end
  endtask

  task automatic test_random_jobs(input int njobs);
    logic [31:0]  words [$];
    logic [31:0]  acc [$];
    logic [127:0] ctq [$];
    logic [31:0]  expo [$];
    logic [127:0] blk_prev, exp_blk;
    logic [31:0]  out_prev;
    int nb, pi, nblk, nout, cyc;
    bit exp_done, done_next, finished, blk_hold, out_hold;
    do_clear();
    for (int j = 0; j < njobs; j++) begin
      idle_inputs();
      tick();
      nb = $urandom_range(1, 4);
      words.delete(); acc.delete(); ctq.delete(); expo.delete();
      for (int i = 0; i < nb * 4 + 4; i++) words.push_back($urandom);
      pi = 0; nblk = 0; nout = 0; cyc = 0;
      exp_done = 0; done_next = 0; finished = 0; blk_hold = 0; out_hold = 0;
      blk_prev = '0; out_prev = '0;
      start_i = 1'b1; num_blocks_i = CNT_W'(nb);
      tick();
      start_i = 1'b0;
      while (!finished && cyc < 600) begin
        checks++;
        if ({busy_o, done_o} !== (exp_done ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL rnd_state job %0d cyc %0d: got busy,done=%b expected %b", j, cyc,
                   {busy_o, done_o}, (exp_done ? 2'b01 : 2'b10));
        end
        if (exp_done) begin
          finished = 1;
        end else begin
          if (pi >= nb * 4) begin
            checks++;
            if (pt_ready_o !== 1'b0) begin
              errors++;
              $display("FAIL rnd_pt_over job %0d: got pt_ready=%b expected 0", j, pt_ready_o);
            end
          end
          pt_valid_i = (pi < words.size()) && ($urandom_range(0, 3) != 0);
          pt_data_i  = (pi < words.size()) ? words[pi] : '0;
          if (blk_hold) begin
            checks++;
            if (blk_data_o !== blk_prev || blk_valid_o !== 1'b1) begin
              errors++;
              $display("FAIL rnd_blk_stable: got %h expected %h", blk_data_o, blk_prev);
            end
          end
          blk_ready_i = 1'($urandom_range(0, 1));
          if (blk_valid_o && blk_ready_i) begin
            exp_blk = (acc.size() >= 4 * nblk + 4) ?
                      pack4(acc[4*nblk], acc[4*nblk+1], acc[4*nblk+2], acc[4*nblk+3]) : '0;
            checks++;
            if (acc.size() < 4 * nblk + 4 || blk_data_o !== exp_blk) begin
              errors++;
              $display("FAIL rnd_blk job %0d blk %0d: got %h expected %h", j, nblk, blk_data_o, exp_blk);
            end
            ctq.push_back({$urandom, $urandom, $urandom, $urandom});
            nblk++;
          end
          blk_hold = blk_valid_o && !blk_ready_i;
          blk_prev = blk_data_o;
          ct_valid_i = (ctq.size() != 0) && ($urandom_range(0, 2) != 0);
          ct_data_i  = (ctq.size() != 0) ? ctq[0] : '0;
          if (ct_valid_i && ct_ready_o) begin
            for (int k = 0; k < 4; k++) expo.push_back(ct_word(ctq[0], k));
            ctq.pop_front();
          end
          if (out_hold) begin
            checks++;
            if (out_data_o !== out_prev || out_valid_o !== 1'b1) begin
              errors++;
              $display("FAIL rnd_out_stable: got %h expected %h", out_data_o, out_prev);
            end
          end
          out_ready_i = 1'($urandom_range(0, 1));
          if (out_valid_o && out_ready_i) begin
            checks++;
            if (expo.size() == 0) begin
              errors++;
              $display("FAIL rnd_out_extra job %0d: got %h expected no word", j, out_data_o);
            end else begin
              if (out_data_o !== expo[0]) begin
                errors++;
                $display("FAIL rnd_out job %0d word %0d: got %h expected %h", j, nout, out_data_o, expo[0]);
              end
              expo.pop_front();
            end
            nout++;
            if (nout == nb * 4) done_next = 1;
          end
          out_hold = out_valid_o && !out_ready_i;
          out_prev = out_data_o;
          if (pt_valid_i && pt_ready_o) begin
            acc.push_back(words[pi]);
            pi++;
          end
          tick();
          cyc++;
          exp_done = done_next;
        end
      end
      idle_inputs();
      checks++;
      if (!finished || pi != nb * 4 || nblk != nb) begin
        errors++;
        $display("FAIL rnd_job %0d: got finished=%0d words=%0d blocks=%0d expected 1 %0d %0d",
                 j, finished, pi, nblk, nb * 4, nb);
      end
    end
  endtask

  initial begin
    clear = 1'b1;
    idle_inputs();
    test_reset();
    test_single_block();
    test_zero_blocks();
    test_backpressure();
    test_count_enforcement();
    test_clear_mid_job();
    test_random_jobs(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish within 500000 ns expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
